// File: rtl/dct2_1d_stream.sv
// Streaming 1D DCT-II (N = 4..N_MAX): latches one vector, emits N rounded and
// saturated coefficients in order k=0..N-1 under a valid/ready handshake.
module dct2_1d_stream #(
   parameter int unsigned LOG2_NMAX = 5,
   parameter int unsigned IN_W      = 16,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned ACC_W     = IN_W + 8 + LOG2_NMAX
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [(2**LOG2_NMAX)*IN_W-1:0]       x_in,
   input  logic [1:0]                           size_in,
   input  logic [4:0]                           shift_in,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic signed [OUT_W-1:0]              y_out,
   output logic [4:0]                           y_idx,
   output logic                                 y_last,
   output logic                                 y_sat
);

   localparam int unsigned N_MAX = 2**LOG2_NMAX;
   localparam int unsigned RND_W = ACC_W + 32;
   localparam int unsigned X_W   = N_MAX * IN_W;

   // Quarter-wave cosine table: first column of the 64-point DCT-II basis.
   localparam logic [6:0] COS_Q [0:64] = '{
      7'd64, 7'd91, 7'd90, 7'd90, 7'd90, 7'd90, 7'd90, 7'd90,
      7'd89, 7'd88, 7'd88, 7'd87, 7'd87, 7'd86, 7'd85, 7'd84,
      7'd83, 7'd83, 7'd82, 7'd81, 7'd80, 7'd79, 7'd78, 7'd77,
      7'd75, 7'd73, 7'd73, 7'd71, 7'd70, 7'd69, 7'd67, 7'd65,
      7'd64, 7'd62, 7'd61, 7'd59, 7'd57, 7'd56, 7'd54, 7'd52,
      7'd50, 7'd48, 7'd46, 7'd44, 7'd43, 7'd41, 7'd38, 7'd37,
      7'd36, 7'd33, 7'd31, 7'd28, 7'd25, 7'd24, 7'd22, 7'd20,
      7'd18, 7'd15, 7'd13, 7'd11, 7'd9,  7'd7,  7'd4,  7'd2,
      7'd0
   };

   typedef enum logic {IDLE, RUN} state_t;

   state_t                   state;
   logic [X_W-1:0]           x_r;
   logic [2:0]               log2n_r;
   logic [4:0]               sh_r;
   logic [5:0]               k_r;

   logic [5:0]               n_len;
   logic                     load;
   logic [1:0]               code_c;
   logic [2:0]               log2n_in;

   logic [7:0]               kk;
   logic [7:0]               p;
   logic signed [7:0]        c;
   logic signed [IN_W-1:0]   xs;
   logic signed [ACC_W-1:0]  acc;
   logic signed [RND_W-1:0]  rnd;
   logic signed [RND_W-1:0]  sum;
   logic signed [RND_W-1:0]  res;
   logic signed [OUT_W-1:0]  y_nxt;
   logic                     sat_nxt;

   // Signed basis value for phase p (in 1/256 of a full period) via quadrant folding.
   function automatic logic signed [7:0] coef_f(input logic [7:0] ph);
      logic [6:0] mag;
      logic       neg;
      if (ph <= 8'd64) begin
         mag = COS_Q[7'(ph)];
         neg = 1'b0;
      end else if (ph <= 8'd128) begin
         mag = COS_Q[7'(8'd128 - ph)];
         neg = 1'b1;
      end else if (ph <= 8'd192) begin
         mag = COS_Q[7'(ph - 8'd128)];
         neg = 1'b1;
      end else begin
         mag = COS_Q[7'(9'd256 - 9'(ph))];
         neg = 1'b0;
      end
      return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   endfunction

   always_comb begin
      code_c   = (size_in > 2'(LOG2_NMAX - 2)) ? 2'(LOG2_NMAX - 2) : size_in;
      log2n_in = 3'(code_c) + 3'd2;
      n_len    = 6'd1 << log2n_r;
      load     = (state == RUN) && (k_r < n_len) && (!out_valid || out_ready);
   end

   // Parallel multiply-accumulate over the latched vector for the current k.
   always_comb begin
      acc = '0;
      p   = '0;
      c   = '0;
      xs  = '0;
      kk  = 8'(k_r) << (3'd6 - log2n_r);
      for (int n = 0; n < int'(N_MAX); n++) begin
         p  = kk * 8'(2 * n + 1);
         c  = coef_f(p);
         xs = x_r[n*IN_W +: IN_W];
         if (6'(n) < n_len)
            acc = acc + ACC_W'(xs) * ACC_W'(c);
      end
      rnd = (sh_r == 5'd0) ? '0 : (RND_W'(1) << (sh_r - 5'd1));
      sum = RND_W'(acc) + rnd;
      res = sum >>> sh_r;
      if ((&res[RND_W-1:OUT_W-1]) || !(|res[RND_W-1:OUT_W-1])) begin
         y_nxt   = res[OUT_W-1:0];
         sat_nxt = 1'b0;
      end else if (res[RND_W-1]) begin
         y_nxt   = {1'b1, {(OUT_W-1){1'b0}}};
         sat_nxt = 1'b1;
      end else begin
         y_nxt   = {1'b0, {(OUT_W-1){1'b1}}};
         sat_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         x_r       <= '0;
         log2n_r   <= '0;
         sh_r      <= '0;
         k_r       <= '0;
         out_valid <= 1'b0;
         y_out     <= '0;
         y_idx     <= '0;
         y_last    <= 1'b0;
         y_sat     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  x_r      <= x_in;
                  log2n_r  <= log2n_in;
                  sh_r     <= shift_in;
                  k_r      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (load) begin
                  y_out     <= y_nxt;
                  y_sat     <= sat_nxt;
                  y_idx     <= 5'(k_r);
                  y_last    <= (k_r == n_len - 6'd1);
                  out_valid <= 1'b1;
                  k_r       <= k_r + 6'd1;
               end else if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  if (y_last) begin
                     state    <= IDLE;
                     in_ready <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dct2_1d_stream.sv
// Bench for dct2_1d_stream: directed table vectors, handshake corner cases and
// random vectors checked against an arithmetic DCT-II reference.
module tb_dct2_1d_stream;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [511:0]   x_in;
   logic [1:0]     size_in;
   logic [4:0]     shift_in;
   logic           out_valid;
   logic           out_ready;
   logic signed [15:0] y_out;
   logic [4:0]     y_idx;
   logic           y_last;
   logic           y_sat;

   dct2_1d_stream dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .size_in(size_in), .shift_in(shift_in),
      .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out),
      .y_idx(y_idx), .y_last(y_last), .y_sat(y_sat)
   );

   always #5 clk = ~clk;

   localparam int COSB [0:64] = '{
      64, 91, 90, 90, 90, 90, 90, 90, 89, 88, 88, 87, 87, 86, 85, 84,
      83, 83, 82, 81, 80, 79, 78, 77, 75, 73, 73, 71, 70, 69, 67, 65,
      64, 62, 61, 59, 57, 56, 54, 52, 50, 48, 46, 44, 43, 41, 38, 37,
      36, 33, 31, 28, 25, 24, 22, 20, 18, 15, 13, 11, 9, 7, 4, 2, 0
   };

   typedef struct {
      logic [1:0] size;
      int         x[4];
      int         sh;
      int         y[4];
   } vec_t;

   int  n_vec = 0;
   int  n_err = 0;
   int  xv[32];
   int  exp_y[32];
   bit  exp_s[32];
   vec_t tbl[4];

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: direct sum of x[n]*T_N[k][n], then round, shift and clamp.
   function automatic void model(input int code, input int sh);
      int nn = 4 << code;
      for (int k = 0; k < nn; k++) begin
         longint acc = 0;
         longint r;
         for (int n = 0; n < nn; n++) begin
            int ph = (k * (64 / nn) * (2 * n + 1)) % 256;
            int cf;
            if (ph <= 64)       cf = COSB[ph];
            else if (ph <= 128) cf = -COSB[128 - ph];
            else if (ph <= 192) cf = -COSB[ph - 128];
            else                cf = COSB[256 - ph];
            acc += longint'(xv[n]) * cf;
         end
         r = (acc + ((sh > 0) ? (longint'(1) << (sh - 1)) : 0)) >>> sh;
         if (r > 32767)       begin exp_y[k] = 32767;  exp_s[k] = 1'b1; end
         else if (r < -32768) begin exp_y[k] = -32768; exp_s[k] = 1'b1; end
         else                 begin exp_y[k] = int'(r); exp_s[k] = 1'b0; end
      end
   endfunction

   task automatic send(input int code, input int sh, input bit hold);
      int t = 0;
      in_valid = 1'b1;
      size_in  = 2'(code);
      shift_in = 5'(sh);
      for (int n = 0; n < 32; n++) x_in[n*16 +: 16] = 16'(xv[n]);
      while (!in_ready && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 100) chk("accept_timeout", t, 0);
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
   endtask

   // Entered one step after the accept edge; drains n coefficients.
   task automatic collect(input int n, input bit rnd_ready, input bit timing);
      int   got = 0;
      int   cyc = 0;
      int   first = -1;
      bit   held = 1'b0;
      bit   ir_seen = 1'b0;
      logic [22:0] hv = '0;
      while (got < n && cyc < 4000) begin
         if (in_ready) ir_seen = 1'b1;
         if (held) chk("stall_hold", {y_out, y_idx, y_last, y_sat}, hv);
         held = 1'b0;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid) begin
            if (first < 0) first = cyc;
            if (out_ready) begin
               chk($sformatf("y_out[%0d]", got), y_out, exp_y[got]);
               chk("y_idx", y_idx, got);
               chk("y_last", y_last, (got == n - 1));
               chk($sformatf("y_sat[%0d]", got), y_sat, exp_s[got]);
               got++;
            end else begin
               held = 1'b1;
               hv   = {y_out, y_idx, y_last, y_sat};
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      chk("out_count", got, n);
      chk("in_ready_busy", ir_seen, 0);
      chk("in_ready_end", in_ready, 1);
      chk("out_valid_end", out_valid, 0);
      if (timing) begin
         chk("first_latency", first, 1);
         chk("return_latency", cyc, n + 1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      x_in = '0; size_in = '0; shift_in = '0;

      tbl[0].size = 2'b00; tbl[0].x = '{64, 64, 64, 64}; tbl[0].sh = 8; tbl[0].y = '{64, 0, 0, 0};
      tbl[1].size = 2'b00; tbl[1].x = '{100, 0, 0, 0};   tbl[1].sh = 0; tbl[1].y = '{6400, 8300, 6400, 3600};
      tbl[2].size = 2'b00; tbl[2].x = '{1, 0, 0, 0};     tbl[2].sh = 7; tbl[2].y = '{1, 1, 1, 0};
      tbl[3].size = 2'b00; tbl[3].x = '{-1, 0, 0, 0};    tbl[3].sh = 7; tbl[3].y = '{0, -1, 0, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_outputs", {out_valid, y_out, y_idx, y_last, y_sat}, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);

      // Directed 4-point vectors.
      for (int i = 0; i < 4; i++) begin
         for (int n = 0; n < 32; n++) xv[n] = (n < 4) ? tbl[i].x[n] : 0;
         for (int k = 0; k < 4; k++) begin exp_y[k] = tbl[i].y[k]; exp_s[k] = 1'b0; end
         send(int'(tbl[i].size), tbl[i].sh, 1'b0);
         collect(4, 1'b0, 1'b1);
      end

      // 32-point impulse: first column of the basis.
      for (int n = 0; n < 32; n++) xv[n] = (n == 0) ? 1 : 0;
      model(3, 0);
      exp_y[0] = 64; exp_y[1] = 90; exp_y[8] = 83; exp_y[16] = 64; exp_y[24] = 36;
      send(3, 0, 1'b0);
      collect(32, 1'b0, 1'b1);

      // 32-point full-scale DC: only Y[0] saturates.
      for (int n = 0; n < 32; n++) xv[n] = 32767;
      for (int k = 0; k < 32; k++) begin exp_y[k] = (k == 0) ? 32767 : 0; exp_s[k] = (k == 0); end
      send(3, 0, 1'b0);
      collect(32, 1'b0, 1'b0);

      // 16-point impulse with random backpressure and in_valid held high.
      for (int n = 0; n < 32; n++) xv[n] = (n == 0) ? 1 : 0;
      model(2, 0);
      send(2, 0, 1'b1);
      collect(16, 1'b1, 1'b0);
      for (int n = 0; n < 32; n++) xv[n] = int'($urandom_range(0, 65535)) - 32768;
      for (int n = 0; n < 32; n++) x_in[n*16 +: 16] = 16'(xv[n]);
      shift_in = 5'd9;
      model(2, 9);
      @(posedge clk); #1;
      in_valid = 1'b0;
      collect(16, 1'b1, 1'b0);

      // Reset in the middle of a 32-point run.
      for (int n = 0; n < 32; n++) xv[n] = int'($urandom_range(0, 65535)) - 32768;
      send(3, 10, 1'b0);
      begin
         int t = 0;
         out_ready = 1'b1;
         while (!(out_valid && y_idx == 5'd5) && t < 200) begin
            @(posedge clk); #1;
            t++;
         end
         chk("reach_idx5", y_idx, 5);
      end
      rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("hold_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("release_in_ready", in_ready, 1);
      chk("release_out_valid", out_valid, 0);
      for (int n = 0; n < 32; n++) xv[n] = (n < 4) ? 64 : 0;
      for (int k = 0; k < 4; k++) begin exp_y[k] = (k == 0) ? 64 : 0; exp_s[k] = 1'b0; end
      send(0, 8, 1'b0);
      collect(4, 1'b0, 1'b1);

      // Random vectors of every size, random shift and backpressure.
      for (int i = 0; i < 24; i++) begin
         int code = int'($urandom_range(0, 3));
         int sh   = (i % 3 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(4, 12));
         for (int n = 0; n < 32; n++) xv[n] = int'($urandom_range(0, 65535)) - 32768;
         model(code, sh);
         send(code, sh, 1'b0);
         collect(4 << code, (i % 2 == 1), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
